// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one SIZE-bit shift/rotate datapath between two requesters (A and B).
//   Round-robin arbitration picks a winner in IDLE, its operands are captured
//   on the handshake, the result is computed in a single registered EXEC cycle,
//   and it is then held in DONE until the consumer takes it.
//
// Parameters
//   SIZE        data width (expected to be a power of two so that every
//               howmany value is a legal rotate amount)
//   HW          howmany width, $clog2(SIZE)
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   a_valid / a_ready           requester A handshake
//   a_rors, a_lorr              1 = rotate / 0 = logical shift; 1 = left / 0 = right
//   a_howmany, a_data           shift amount and operand
//   b_*                         same set for requester B
//   res_valid / res_ready       result handshake
//   res_data, res_id            result value; 0 = from A, 1 = from B
//
// Optional feature (macro SHIFT_ARB_STATS_EN)
//   stat_clr                    synchronous clear of both counters (wins over
//                               a same-cycle increment)
//   stat_a_cnt, stat_b_cnt      saturating per-requester handshake counters
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int SIZE = 8,
  parameter int HW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_rors,
  input  logic            a_lorr,
  input  logic [HW-1:0]   a_howmany,
  input  logic [SIZE-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic            b_rors,
  input  logic            b_lorr,
  input  logic [HW-1:0]   b_howmany,
  input  logic [SIZE-1:0] b_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_data,
  output logic            res_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [15:0]     stat_a_cnt,
  output logic [15:0]     stat_b_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ptr_q = 1 means the next contested grant goes to B.
  logic ptr_q, ptr_d;
  logic grant_a, grant_b, accept;

  // Captured operation
  logic            op_rors_q;
  logic            op_lorr_q;
  logic [HW-1:0]   op_amt_q;
  logic [SIZE-1:0] op_data_q;
  logic            op_id_q;

  // Held result
  logic [SIZE-1:0] res_data_q;
  logic            res_id_q;

  // ---------------------------------------------------------------------------
  // Next-state / grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !ptr_q)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_d = EXEC;
          // After serving A, favour B next time, and vice versa.
          ptr_d   = grant_a;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = grant_a | grant_b;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture on the handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rors_q <= 1'b0;
      op_lorr_q <= 1'b0;
      op_amt_q  <= '0;
      op_data_q <= '0;
      op_id_q   <= 1'b0;
    end else if (accept) begin
      op_rors_q <= grant_a ? a_rors    : b_rors;
      op_lorr_q <= grant_a ? a_lorr    : b_lorr;
      op_amt_q  <= grant_a ? a_howmany : b_howmany;
      op_data_q <= grant_a ? a_data    : b_data;
      op_id_q   <= grant_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter datapath
  //   Rotates are taken from a doubled copy of the operand: shifting {d,d}
  //   left leaves the left-rotated word in the upper half, shifting it right
  //   leaves the right-rotated word in the lower half. An amount of 0 passes
  //   the operand straight through.
  // ---------------------------------------------------------------------------
  logic [2*SIZE-1:0] dbl, dbl_l, dbl_r;
  logic [SIZE-1:0]   exec_result;

  assign dbl   = {op_data_q, op_data_q};
  assign dbl_l = dbl << op_amt_q;
  assign dbl_r = dbl >> op_amt_q;

  always_comb begin
    exec_result = '0;
    case ({op_rors_q, op_lorr_q})
      2'b00: exec_result = op_data_q >> op_amt_q;
      2'b01: exec_result = op_data_q << op_amt_q;
      2'b10: exec_result = dbl_r[SIZE-1:0];
      2'b11: exec_result = dbl_l[2*SIZE-1:SIZE];
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      res_data_q <= exec_result;
      res_id_q   <= op_id_q;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Handshake counters (saturating, clear has priority)
  // ---------------------------------------------------------------------------
  logic [15:0] stat_a_cnt_q, stat_b_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_cnt_q <= '0;
      stat_b_cnt_q <= '0;
    end else if (stat_clr) begin
      stat_a_cnt_q <= '0;
      stat_b_cnt_q <= '0;
    end else begin
      if (grant_a && (stat_a_cnt_q != 16'hFFFF)) begin
        stat_a_cnt_q <= stat_a_cnt_q + 16'd1;
      end
      if (grant_b && (stat_b_cnt_q != 16'hFFFF)) begin
        stat_b_cnt_q <= stat_b_cnt_q + 16'd1;
      end
    end
  end

  assign stat_a_cnt = stat_a_cnt_q;
  assign stat_b_cnt = stat_b_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Self-checking bench for shift_arbiter (SIZE = 8). A table of single-request
//   vectors with hand-computed results, hand-written multi-cycle sequences
//   (alternating grants, stalled consumer, reset during EXEC, optional
//   counters) and a randomized run checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int SIZE = 8;
  localparam int HW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_valid = 1'b0, a_rors = 1'b0, a_lorr = 1'b0;
  logic [HW-1:0]   a_howmany = '0;
  logic [SIZE-1:0] a_data = '0;
  logic            b_valid = 1'b0, b_rors = 1'b0, b_lorr = 1'b0;
  logic [HW-1:0]   b_howmany = '0;
  logic [SIZE-1:0] b_data = '0;
  logic            res_ready = 1'b0;
  logic            a_ready, b_ready, res_valid, res_id;
  logic [SIZE-1:0] res_data;
`ifdef SHIFT_ARB_STATS_EN
  logic            stat_clr = 1'b0;
  logic [15:0]     stat_a_cnt, stat_b_cnt;
`endif

  always #5 clk = ~clk;

  shift_arbiter #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rors    (a_rors),
    .a_lorr    (a_lorr),
    .a_howmany (a_howmany),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rors    (b_rors),
    .b_lorr    (b_lorr),
    .b_howmany (b_howmany),
    .b_data    (b_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_a_cnt(stat_a_cnt),
    .stat_b_cnt(stat_b_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Model state: who was granted last (1 = B). After reset A is favoured,
  // which is the same as "B was served last".
  bit last_b = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural reference: shifts as multiply/divide by powers of two,
  // rotates as a bit-position permutation modulo SIZE.
  function automatic logic [7:0] ref_op(input bit rors, input bit lorr, input int n,
                                        input logic [7:0] d);
    int v;
    logic [7:0] r;
    if (!rors) begin
      v = int'(d);
      if (lorr) v = v * (1 << n);
      else      v = v / (1 << n);
      return 8'(v % 256);
    end
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (lorr) r[(i + n) % SIZE] = d[i];
      else      r[(i + SIZE - n) % SIZE] = d[i];
    end
    return r;
  endfunction

  task automatic rand_a();
    a_rors    = 1'($urandom);
    a_lorr    = 1'($urandom);
    a_howmany = 3'($urandom_range(0, 7));
    a_data    = 8'($urandom);
  endtask

  task automatic rand_b();
    b_rors    = 1'($urandom);
    b_lorr    = 1'($urandom);
    b_howmany = 3'($urandom_range(0, 7));
    b_data    = 8'($urandom);
  endtask

  // One complete operation. Called one time unit after a rising edge while
  // the DUT is idle and at least one request is presented. The consumer
  // stalls for wait_cycles DONE cycles before taking the result. The winner
  // either drops its request (keep=0) or presents a fresh random one.
  task automatic do_op(input int wait_cycles, input bit keep,
                       output logic [7:0] got_d, output logic got_id);
    bit         gb;
    logic [7:0] exp_d;
    #1;
    gb    = b_valid && (!a_valid || !last_b);
    exp_d = gb ? ref_op(b_rors, b_lorr, int'(b_howmany), b_data)
               : ref_op(a_rors, a_lorr, int'(a_howmany), a_data);
    chk("grant_a_ready", a_ready, !gb);
    chk("grant_b_ready", b_ready, gb);
    @(posedge clk); #1;
    last_b = gb;
    if (gb) begin
      if (keep) rand_b(); else b_valid = 1'b0;
    end else begin
      if (keep) rand_a(); else a_valid = 1'b0;
    end
    chk("exec_res_valid", res_valid, 1'b0);
    chk("exec_a_ready", a_ready, 1'b0);
    chk("exec_b_ready", b_ready, 1'b0);
    @(posedge clk); #1;
    got_d  = res_data;
    got_id = res_id;
    for (int k = 0; k <= wait_cycles; k++) begin
      if (k == wait_cycles) res_ready = 1'b1;
      chk("done_res_valid", res_valid, 1'b1);
      chk("done_res_data", res_data, exp_d);
      chk("done_res_id", res_id, gb);
      chk("done_a_ready", a_ready, 1'b0);
      chk("done_b_ready", b_ready, 1'b0);
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    chk("consumed_res_valid", res_valid, 1'b0);
  endtask

  typedef struct {
    bit         use_b;
    bit         rors;
    bit         lorr;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] got_d;
  logic       got_id;
  bit         exp_ids[4];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 3'd3, 8'b1000_0001, 8'b0000_1100};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'h01, 8'h80};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 3'd0, 8'hA5, 8'hA5};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 3'd3, 8'h96, 8'hD2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hF0, 8'h3C};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 3'd2, 8'hF0, 8'hC0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 3'd7, 8'hFF, 8'h80};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 3'd7, 8'h80, 8'h01};
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};

    // ---------------- reset values ----------------
    #12;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_res_id", res_id, 1'b0);
`ifdef SHIFT_ARB_STATS_EN
    chk("rst_stat_a", stat_a_cnt, 16'd0);
    chk("rst_stat_b", stat_b_cnt, 16'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table of single requests ----------------
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].use_b) begin
        b_rors = tbl[i].rors; b_lorr = tbl[i].lorr;
        b_howmany = tbl[i].amt; b_data = tbl[i].data; b_valid = 1'b1;
      end else begin
        a_rors = tbl[i].rors; a_lorr = tbl[i].lorr;
        a_howmany = tbl[i].amt; a_data = tbl[i].data; a_valid = 1'b1;
      end
      do_op(0, 1'b0, got_d, got_id);
      chk("table_res_data", got_d, tbl[i].exp);
      chk("table_res_id", got_id, tbl[i].use_b);
      $display("vec %0d: id=%0d data=%02h res=%02h", i, got_id, tbl[i].data, got_d);
    end

    // ---------------- both held valid: A, B, A, B ----------------
    rand_a(); rand_b();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b1, got_d, got_id);
      chk("alt_res_id", got_id, exp_ids[i]);
      $display("alt op %0d: id=%0d res=%02h", i, got_id, got_d);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // ---------------- consumer stalls 5 cycles in DONE ----------------
    rand_a(); rand_b();
    a_valid = 1'b1; b_valid = 1'b1;
    do_op(5, 1'b0, got_d, got_id);
    $display("stall op: id=%0d res=%02h", got_id, got_d);
    do_op(0, 1'b0, got_d, got_id);
    $display("after stall op: id=%0d res=%02h", got_id, got_d);

    // ---------------- reset during EXEC ----------------
    rand_a();
    a_valid = 1'b1;
    #1;
    chk("pre_rst_a_ready", a_ready, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_res_data", res_data, 8'h00);
    chk("midrst_res_id", res_id, 1'b0);
    chk("midrst_a_ready", a_ready, 1'b0);
    chk("midrst_b_ready", b_ready, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    last_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("postrst_res_valid", res_valid, 1'b0);
    end
    rand_a(); rand_b();
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("postrst_ptr_a_ready", a_ready, 1'b1);
    chk("postrst_ptr_b_ready", b_ready, 1'b0);
    do_op(0, 1'b0, got_d, got_id);
    $display("post-reset op: id=%0d res=%02h", got_id, got_d);
    do_op(0, 1'b0, got_d, got_id);
    $display("post-reset op: id=%0d res=%02h", got_id, got_d);

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 30; i++) begin
      if (!a_valid && ($urandom % 2 == 1)) begin rand_a(); a_valid = 1'b1; end
      if (!b_valid && ($urandom % 2 == 1)) begin rand_b(); b_valid = 1'b1; end
      if (!a_valid && !b_valid) begin rand_a(); a_valid = 1'b1; end
      do_op(int'($urandom_range(0, 2)), 1'($urandom), got_d, got_id);
      $display("rand op %0d: id=%0d res=%02h", i, got_id, got_d);
    end
    a_valid = 1'b0; b_valid = 1'b0;

`ifdef SHIFT_ARB_STATS_EN
    // ---------------- handshake counters ----------------
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_stat_a", stat_a_cnt, 16'd0);
    chk("clr_stat_b", stat_b_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      rand_a(); a_valid = 1'b1;
      do_op(0, 1'b0, got_d, got_id);
    end
    for (int i = 0; i < 2; i++) begin
      rand_b(); b_valid = 1'b1;
      do_op(0, 1'b0, got_d, got_id);
    end
    chk("stat_a_cnt", stat_a_cnt, 16'd3);
    chk("stat_b_cnt", stat_b_cnt, 16'd2);
    $display("stats: a=%0d b=%0d", stat_a_cnt, stat_b_cnt);
    // Clear held across a handshake must win over the increment.
    stat_clr = 1'b1;
    rand_a(); a_valid = 1'b1;
    do_op(0, 1'b0, got_d, got_id);
    stat_clr = 1'b0;
    chk("clr_over_inc_a", stat_a_cnt, 16'd0);
    chk("clr_over_inc_b", stat_b_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
